dp_ram_port_arbiter: RTL and testbench

Two-master arbiter for the single 32-bit data port of the testbench dual-port RAM. It shares the port between the core data master (m0) and a secondary master (m1), such as the debug/loader agent. Each master uses a req/gnt/rvalid handshake. The block drives the RAM data port and routes the 1-cycle-latency read data back to the master that owns it.

---
 rtl/dp_ram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_dp_ram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_port_arbiter.sv
// dp_ram_port_arbiter
//
// Shares the single 32-bit data port of the dual-port RAM between two masters.
// m0 is the core data master and m1 is a secondary master, such as a debug or
// loader agent. Both masters use a req/gnt/rvalid handshake. The grant is
// combinational. The response arrives one cycle after the grant and goes back
// to the master that owns it.
//
// Parameters
//   ADDR_WIDTH  byte-address width of the RAM data port
//   FIXED_PRIO  0: round-robin between m0 and m1, 1: m0 always wins
//
// Ports
//   clk_i, rst_ni                 clock and asynchronous active-low reset
//   mX_req_i / mX_gnt_o           request and same-cycle grant for master X
//   mX_addr_i/we_i/be_i/wdata_i   access attributes, held until granted
//   mX_rvalid_o / mX_rdata_o      response one cycle after grant (rdata 0 on writes)
//   ram_en_o .. ram_wdata_o       RAM data-port command (all zero when idle)
//   ram_rdata_i                   RAM read data, registered one cycle after ram_en_o

module dp_ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,

  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  // Owner of the response in flight.
  localparam logic [1:0] OwnNone = 2'b00;
  localparam logic [1:0] OwnM0   = 2'b01;
  localparam logic [1:0] OwnM1   = 2'b10;

  logic       last_m1_q, last_m1_d;  // 1: m1 was granted most recently
  logic [1:0] owner_q, owner_d;
  logic       read_q, read_d;

  logic gnt0, gnt1;

  // m0 wins a conflict under fixed priority, or under round-robin when m1
  // had the last grant. Grants are suppressed while reset is held.
  always_comb begin
    gnt0 = rst_ni & m0_req_i & (~m1_req_i | FIXED_PRIO | last_m1_q);
    gnt1 = rst_ni & m1_req_i & ~gnt0;
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Drive the RAM command from the winner. Everything is zero when idle.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    ram_wdata_o = 32'h0;
    if (gnt0) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m0_addr_i;
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_be_i;
      ram_wdata_o = m0_wdata_i;
    end else if (gnt1) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = m1_addr_i;
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_be_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  always_comb begin
    last_m1_d = last_m1_q;
    owner_d   = OwnNone;
    read_d    = 1'b0;
    if (gnt0) begin
      last_m1_d = 1'b0;
      owner_d   = OwnM0;
      read_d    = ~m0_we_i;
    end else if (gnt1) begin
      last_m1_d = 1'b1;
      owner_d   = OwnM1;
      read_d    = ~m1_we_i;
    end
  end

  // The pointer resets to m1 so that m0 wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_m1_q <= 1'b1;
      owner_q   <= OwnNone;
      read_q    <= 1'b0;
    end else begin
      last_m1_q <= last_m1_d;
      owner_q   <= owner_d;
      read_q    <= read_d;
    end
  end

  // Route the response. A write produces rvalid with zero data.
  always_comb begin
    m0_rvalid_o = (owner_q == OwnM0);
    m1_rvalid_o = (owner_q == OwnM1);
    m0_rdata_o  = (m0_rvalid_o && read_q) ? ram_rdata_i : 32'h0;
    m1_rdata_o  = (m1_rvalid_o && read_q) ? ram_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
module tb_dp_ram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;

  logic        m0_req, m0_gnt, m0_we, m0_rvalid;
  logic [7:0]  m0_addr;
  logic [3:0]  m0_be;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_gnt, m1_we, m1_rvalid;
  logic [7:0]  m1_addr;
  logic [3:0]  m1_be;
  logic [31:0] m1_wdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;

  // Fixed-priority instance: its own requests, shared attributes.
  logic        p_m0_req, p_m0_gnt, p_m0_rvalid;
  logic        p_m1_req, p_m1_gnt, p_m1_rvalid;
  logic [31:0] p_m0_rdata, p_m1_rdata, p_ram_wdata;
  logic        p_ram_en, p_ram_we;
  logic [7:0]  p_ram_addr;
  logic [3:0]  p_ram_be;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:63];

  always #5 clk_i = ~clk_i;

  // Byte-enabled RAM with registered read data.
  always @(posedge clk_i) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:2]];
      end
    end
  end

  dp_ram_port_arbiter #(.ADDR_WIDTH(8), .FIXED_PRIO(1'b0)) u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m0_req_i    (m0_req),
    .m0_gnt_o    (m0_gnt),
    .m0_addr_i   (m0_addr),
    .m0_we_i     (m0_we),
    .m0_be_i     (m0_be),
    .m0_wdata_i  (m0_wdata),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_gnt_o    (m1_gnt),
    .m1_addr_i   (m1_addr),
    .m1_we_i     (m1_we),
    .m1_be_i     (m1_be),
    .m1_wdata_i  (m1_wdata),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  dp_ram_port_arbiter #(.ADDR_WIDTH(8), .FIXED_PRIO(1'b1)) u_dut_fixed (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m0_req_i    (p_m0_req),
    .m0_gnt_o    (p_m0_gnt),
    .m0_addr_i   (m0_addr),
    .m0_we_i     (m0_we),
    .m0_be_i     (m0_be),
    .m0_wdata_i  (m0_wdata),
    .m0_rvalid_o (p_m0_rvalid),
    .m0_rdata_o  (p_m0_rdata),
    .m1_req_i    (p_m1_req),
    .m1_gnt_o    (p_m1_gnt),
    .m1_addr_i   (m1_addr),
    .m1_we_i     (m1_we),
    .m1_be_i     (m1_be),
    .m1_wdata_i  (m1_wdata),
    .m1_rvalid_o (p_m1_rvalid),
    .m1_rdata_o  (p_m1_rdata),
    .ram_en_o    (p_ram_en),
    .ram_addr_o  (p_ram_addr),
    .ram_we_o    (p_ram_we),
    .ram_be_o    (p_ram_be),
    .ram_wdata_o (p_ram_wdata),
    .ram_rdata_i (32'h0)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  logic [31:0] bb_exp [3];
  logic        rr_exp [6];

  initial begin
    bb_exp = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    rr_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_1000;
    mem[1] = 32'h0000_2000;
    mem[2] = 32'h0000_3000;
    mem[4] = 32'hDEAD_BEEF;
    ram_rdata = 32'h0;

    rst_ni = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h0; m0_be = 4'hF; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h0; m1_be = 4'hF; m1_wdata = 32'h0;
    p_m0_req = 1'b0; p_m1_req = 1'b0;

    // Requests held during reset must not be granted.
    #1;
    m0_req = 1'b1; m1_req = 1'b1;
    sample();
    check_eq("rst_m0_gnt", m0_gnt, 0);
    check_eq("rst_m1_gnt", m1_gnt, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_m0_rvalid", m0_rvalid, 0);
    check_eq("rst_m1_rvalid", m1_rvalid, 0);
    check_eq("rst_m0_rdata", m0_rdata, 0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    rst_ni = 1'b1;

    // Single read by m0.
    m0_req = 1'b1; m0_addr = 8'h10; m0_we = 1'b0;
    sample();
    check_eq("rd_m0_gnt", m0_gnt, 1);
    check_eq("rd_m1_gnt", m1_gnt, 0);
    check_eq("rd_ram_en", ram_en, 1);
    check_eq("rd_ram_addr", ram_addr, 8'h10);
    check_eq("rd_ram_we", ram_we, 0);
    tick();
    m0_req = 1'b0;
    sample();
    check_eq("rd_m0_rvalid", m0_rvalid, 1);
    check_eq("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check_eq("rd_m1_rvalid", m1_rvalid, 0);
    check_eq("rd_m1_rdata", m1_rdata, 0);
    check_eq("idle_ram_en", ram_en, 0);
    check_eq("idle_ram_addr", ram_addr, 0);
    tick();
    sample();
    check_eq("rd_m0_rvalid_once", m0_rvalid, 0);

    // m1 writes with partial byte enables, then reads back.
    tick();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h20; m1_be = 4'b0101; m1_wdata = 32'hA5A5_A5A5;
    sample();
    check_eq("wr_m1_gnt", m1_gnt, 1);
    check_eq("wr_ram_we", ram_we, 1);
    check_eq("wr_ram_be", ram_be, 4'b0101);
    check_eq("wr_ram_wdata", ram_wdata, 32'hA5A5_A5A5);
    tick();
    m1_we = 1'b0; m1_be = 4'hF; m1_wdata = 32'h0;
    sample();
    check_eq("wr_m1_rvalid", m1_rvalid, 1);
    check_eq("wr_m1_rdata", m1_rdata, 0);
    check_eq("wr_m0_rvalid", m0_rvalid, 0);
    check_eq("rb_m1_gnt", m1_gnt, 1);
    tick();
    m1_req = 1'b0;
    sample();
    check_eq("rb_m1_rvalid", m1_rvalid, 1);
    check_eq("rb_m1_rdata", m1_rdata, 32'h00A5_00A5);

    // Back-to-back m0 reads of 0x0, 0x4, 0x8.
    tick();
    for (int c = 0; c < 4; c++) begin
      m0_req = (c < 3);
      m0_addr = 8'(4 * c);
      sample();
      if (c < 3) check_eq($sformatf("bb_gnt%0d", c), m0_gnt, 1);
      if (c > 0) begin
        check_eq($sformatf("bb_rvalid%0d", c - 1), m0_rvalid, 1);
        check_eq($sformatf("bb_rdata%0d", c - 1), m0_rdata, bb_exp[c - 1]);
        check_eq($sformatf("bb_m1_rvalid%0d", c - 1), m1_rvalid, 0);
      end
      tick();
    end
    sample();
    check_eq("bb_rvalid_end", m0_rvalid, 0);

    // Round-robin conflict for 6 cycles, starting from reset.
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    m0_addr = 8'h10; m1_addr = 8'h00;
    for (int c = 0; c < 7; c++) begin
      m0_req = (c < 6);
      m1_req = (c < 6);
      sample();
      if (c < 6) begin
        check_eq($sformatf("rr_m0_gnt%0d", c), m0_gnt, rr_exp[c]);
        check_eq($sformatf("rr_m1_gnt%0d", c), m1_gnt, !rr_exp[c]);
      end
      if (c > 0) begin
        check_eq($sformatf("rr_m0_rvalid%0d", c - 1), m0_rvalid, rr_exp[c - 1]);
        check_eq($sformatf("rr_m1_rvalid%0d", c - 1), m1_rvalid, !rr_exp[c - 1]);
        check_eq($sformatf("rr_m0_rdata%0d", c - 1), m0_rdata,
                 rr_exp[c - 1] ? 32'hDEAD_BEEF : 32'h0);
        check_eq($sformatf("rr_m1_rdata%0d", c - 1), m1_rdata,
                 rr_exp[c - 1] ? 32'h0 : 32'h0000_1000);
      end
      tick();
    end

    // Fixed priority: m0 holds the port, and m1 gets it once m0 drops.
    for (int c = 0; c < 5; c++) begin
      p_m0_req = (c < 4);
      p_m1_req = 1'b1;
      sample();
      check_eq($sformatf("fp_m0_gnt%0d", c), p_m0_gnt, (c < 4));
      check_eq($sformatf("fp_m1_gnt%0d", c), p_m1_gnt, (c == 4));
      if (c > 0) check_eq($sformatf("fp_m0_rvalid%0d", c), p_m0_rvalid, 1);
      tick();
    end
    p_m0_req = 1'b0; p_m1_req = 1'b0;
    sample();
    check_eq("fp_m1_rvalid", p_m1_rvalid, 1);
    check_eq("fp_m0_rvalid_end", p_m0_rvalid, 0);

    // Reset during an outstanding m0 read. Before reset the last grant is m0.
    tick();
    m0_req = 1'b1; m0_addr = 8'h10;
    sample();
    check_eq("mr_m0_gnt", m0_gnt, 1);
    tick();
    check_eq("mr_rvalid_pre", m0_rvalid, 1);
    rst_ni = 1'b0;
    m0_req = 1'b0;
    #1;
    check_eq("mr_rvalid_in_rst", m0_rvalid, 0);
    tick();
    rst_ni = 1'b1;
    sample();
    check_eq("mr_m0_rvalid_a", m0_rvalid, 0);
    check_eq("mr_m1_rvalid_a", m1_rvalid, 0);
    tick();
    sample();
    check_eq("mr_m0_rvalid_b", m0_rvalid, 0);
    tick();
    m0_req = 1'b1; m1_req = 1'b1;
    sample();
    check_eq("mr_conf_m0_gnt", m0_gnt, 1);
    check_eq("mr_conf_m1_gnt", m1_gnt, 0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
